// File: rtl/load_store_seq.sv
// Byte-serial load/store sequencer: breaks RV32I b/h/w accesses into single-byte
// memory cycles and reassembles/extends load data for a one-cycle response.
module load_store_seq #(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  output logic [2:0]  mem_funct3,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [1:0]  last_q, last_d;
  logic        write_q, write_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] asm_q, asm_d;

  // Decode of the request currently on the input port.
  logic [1:0] req_last;
  logic       req_illegal;
  logic       req_misaligned;

  always_comb begin
    req_last    = 2'd0;
    req_illegal = 1'b0;
    unique case (req_funct3)
      3'b000, 3'b100: req_last = 2'd0;
      3'b001, 3'b101: req_last = 2'd1;
      3'b010:         req_last = 2'd3;
      default:        req_illegal = 1'b1;
    endcase
    // Unsigned variants only exist for loads.
    if (req_write && req_funct3[2]) req_illegal = 1'b1;
    req_misaligned = ALIGN_CHECK &&
                     (((req_last == 2'd1) && req_addr[0]) ||
                      ((req_last == 2'd3) && (req_addr[1:0] != 2'b00)));
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    last_d     = last_q;
    write_d    = write_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    asm_d      = asm_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 32'd0;
    resp_err   = 1'b0;
    mem_addr   = 32'd0;
    mem_wdata  = 32'd0;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    mem_funct3 = 3'b000;

    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          write_d  = req_write;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          last_d   = req_last;
          k_d      = 2'd0;
          asm_d    = 32'd0;
          err_d    = req_illegal || req_misaligned;
          state_d  = (req_illegal || req_misaligned) ? S_RESP : S_ACCESS;
        end
      end

      S_ACCESS: begin
        mem_addr  = addr_q + {30'd0, k_q};
        mem_write = write_q;
        mem_read  = !write_q;
        if (write_q) mem_wdata = {24'd0, wdata_q[{k_q, 3'b000} +: 8]};
        else         asm_d[{k_q, 3'b000} +: 8] = mem_rdata[7:0];
        k_d = k_q + 2'd1;
        if (k_q == last_q) state_d = S_RESP;
      end

      S_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        if (!err_q && !write_q) begin
          unique case (funct3_q)
            3'b000:  resp_rdata = {{24{asm_q[7]}}, asm_q[7:0]};
            3'b001:  resp_rdata = {{16{asm_q[15]}}, asm_q[15:0]};
            3'b100:  resp_rdata = {24'd0, asm_q[7:0]};
            3'b101:  resp_rdata = {16'd0, asm_q[15:0]};
            default: resp_rdata = asm_q;
          endcase
        end
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      k_q      <= 2'd0;
      last_q   <= 2'd0;
      write_q  <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      err_q    <= 1'b0;
      asm_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      last_q   <= last_d;
      write_q  <= write_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      asm_q    <= asm_d;
    end
  end

endmodule

// File: tb/tb_load_store_seq.sv
// Directed bench for load_store_seq: a 256-byte memory model answers the byte
// strobes, and every response is checked against hand-computed values.
module tb_load_store_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_rdata;

  load_store_seq #(.ALIGN_CHECK(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .mem_funct3 (mem_funct3),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Byte memory with combinational, sign-extended read port.
  logic [7:0] mem [256];
  assign mem_rdata = {{24{mem[mem_addr[7:0]][7]}}, mem[mem_addr[7:0]]};

  int          wr_cnt   = 0;
  int          rd_cnt   = 0;
  int          resp_cnt = 0;
  logic [31:0] wr_bytes = 32'd0;
  logic [31:0] wr_addrs = 32'd0;

  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_addr[7:0]] <= mem_wdata[7:0];
      wr_cnt   <= wr_cnt + 1;
      wr_bytes <= {mem_wdata[7:0], wr_bytes[31:8]};
      wr_addrs <= {wr_addrs[23:0], mem_addr[7:0]};
    end
    if (mem_read)   rd_cnt   <= rd_cnt + 1;
    if (resp_valid) resp_cnt <= resp_cnt + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  logic [31:0] r_data;
  logic        r_err;
  int          r_lat;
  int          r_nwr;
  int          r_nrd;

  task automatic do_req(input string tag, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input bit hold);
    int  wb;
    int  rb;
    bit  seen;
    @(negedge clk);
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    req_valid  = 1'b1;
    wb = wr_cnt;
    rb = rd_cnt;
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
    seen   = 1'b0;
    r_lat  = 0;
    r_data = 32'd0;
    r_err  = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      r_lat++;
      if (resp_valid) begin
        seen   = 1'b1;
        r_data = resp_rdata;
        r_err  = resp_err;
      end
    end
    req_valid = 1'b0;
    check({tag, "_resp_seen"}, {31'd0, seen}, 32'd1);
    r_nwr = wr_cnt - wb;
    r_nrd = rd_cnt - rb;
    @(negedge clk);
    check({tag, "_one_pulse"}, {31'd0, resp_valid}, 32'd0);
  endtask

  task automatic expect_resp(input string tag, input int lat, input logic err,
                             input logic [31:0] data, input int nwr, input int nrd);
    check({tag, "_lat"},  r_lat,            lat);
    check({tag, "_err"},  {31'd0, r_err},   {31'd0, err});
    check({tag, "_data"}, r_data,           data);
    check({tag, "_nwr"},  r_nwr,            nwr);
    check({tag, "_nrd"},  r_nrd,            nrd);
  endtask

  int rc;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    #12;
    check("rst_flags", {27'd0, req_ready, resp_valid, resp_err, mem_read, mem_write}, 32'h10);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Word store, then per-byte content and order on the memory bus.
    do_req("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0);
    expect_resp("sw10", 5, 1'b0, 32'h0, 4, 0);
    check("sw10_bytes", wr_bytes, 32'hDEADBEEF);
    check("sw10_addrs", wr_addrs, 32'h10111213);

    do_req("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
    expect_resp("lw10", 5, 1'b0, 32'hDEADBEEF, 0, 4);

    do_req("lh12", 1'b0, 3'b001, 32'h12, 32'h0, 1'b0);
    expect_resp("lh12", 3, 1'b0, 32'hFFFFDEAD, 0, 2);
    do_req("lhu12", 1'b0, 3'b101, 32'h12, 32'h0, 1'b0);
    expect_resp("lhu12", 3, 1'b0, 32'h0000DEAD, 0, 2);
    do_req("lb13", 1'b0, 3'b000, 32'h13, 32'h0, 1'b0);
    expect_resp("lb13", 2, 1'b0, 32'hFFFFFFDE, 0, 1);
    do_req("lbu10", 1'b0, 3'b100, 32'h10, 32'h0, 1'b0);
    expect_resp("lbu10", 2, 1'b0, 32'h000000EF, 0, 1);

    // Misaligned and illegal requests: immediate error, no strobes.
    do_req("lw11", 1'b0, 3'b010, 32'h11, 32'h0, 1'b0);
    expect_resp("lw11", 1, 1'b1, 32'h0, 0, 0);
    do_req("sh13", 1'b1, 3'b001, 32'h13, 32'h1234, 1'b0);
    expect_resp("sh13", 1, 1'b1, 32'h0, 0, 0);
    do_req("f3_011", 1'b0, 3'b011, 32'h10, 32'h0, 1'b0);
    expect_resp("f3_011", 1, 1'b1, 32'h0, 0, 0);
    do_req("sbu", 1'b1, 3'b100, 32'h10, 32'h55, 1'b0);
    expect_resp("sbu", 1, 1'b1, 32'h0, 0, 0);
    check("sbu_mem10", {24'd0, mem[8'h10]}, 32'hEF);

    // req_valid held high while busy must not start a second transaction.
    do_req("busy_sw", 1'b1, 3'b010, 32'h30, 32'hCAFEF00D, 1'b1);
    expect_resp("busy_sw", 5, 1'b0, 32'h0, 4, 0);
    rc = resp_cnt;
    repeat (4) @(negedge clk);
    check("busy_no_2nd_resp", resp_cnt - rc, 32'd0);
    check("busy_mem30", {mem[8'h33], mem[8'h32], mem[8'h31], mem[8'h30]}, 32'hCAFEF00D);

    // Reset mid-store after two bytes have been written.
    @(negedge clk);
    req_write  = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h20;
    req_wdata  = 32'h11223344;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("pre_rst_write", {31'd0, mem_write}, 32'd1);
    reset = 1'b0;
    #1;
    check("arst_flags", {27'd0, req_ready, resp_valid, resp_err, mem_read, mem_write}, 32'h10);
    check("arst_mem_addr", mem_addr, 32'd0);
    check("arst_mem_wdata", mem_wdata, 32'd0);
    rc = resp_cnt;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    check("arst_no_resp", resp_cnt - rc, 32'd0);
    check("arst_ready", {31'd0, req_ready}, 32'd1);
    check("arst_mem20", {24'd0, mem[8'h20]}, 32'h44);
    check("arst_mem21", {24'd0, mem[8'h21]}, 32'h33);
    check("arst_mem22", {24'd0, mem[8'h22]}, 32'h00);

    do_req("lbu21", 1'b0, 3'b100, 32'h21, 32'h0, 1'b0);
    expect_resp("lbu21", 2, 1'b0, 32'h00000033, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_seq.md
LOAD_STORE_SEQ -- requirements
Module: load_store_seq

Parameters
REQ-001 SHALL provide ALIGN_CHECK, default 1: when 1, misaligned halfword/word requests are rejected; when 0, they proceed byte-by-byte from the given address.

Interface
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  1  pipeline presents a load/store request.
REQ-005 SHALL have port req_ready  output  1  unit idle and able to accept a request.
REQ-006 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_funct3  input  3  RV32I width code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-008 SHALL have port req_addr  input  32  byte address of the access.
REQ-009 SHALL have port req_wdata  input  32  store data, LSB-first.
REQ-010 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata  output  32  extended load result; 0 for stores and errors.
REQ-012 SHALL have port resp_err  output  1  misaligned or illegal request, qualified by resp_valid.
REQ-013 SHALL have port mem_addr  output  32  byte address to data memory (MemSum).
REQ-014 SHALL have port mem_wdata  output  32  store byte in bits [7:0], upper bits 0.
REQ-015 SHALL have port mem_write  output  1  byte-store strobe to data memory.
REQ-016 SHALL have port mem_read  output  1  byte-load strobe to data memory.
REQ-017 SHALL have port mem_funct3  output  3  tied to 3'b000 (byte access).
REQ-018 SHALL have port mem_rdata  input  32  combinational sign-extended byte from data memory; only [7:0] is used.

Function
REQ-019 SHALL implement the FSM states IDLE, ACCESS, and RESP; req_ready = 1 only in IDLE.
REQ-020 SHALL accept a request on a rising edge with req_valid & req_ready, latching write, funct3, addr, and wdata; req_valid in any other state is ignored.
REQ-021 SHALL set byte count N = 1 for 000/100, 2 for 001/101, and 4 for 010.
REQ-022 SHALL treat as illegal: funct3 011/110/111, and 100/101 with req_write = 1.
REQ-023 SHALL, when ALIGN_CHECK = 1, treat as misaligned: N = 2 with addr[0] = 1, and N = 4 with addr[1:0] != 0.
REQ-024 SHALL move from IDLE to RESP with resp_err = 1 on an illegal or misaligned request; no mem_read/mem_write is asserted.
REQ-025 SHALL otherwise move from IDLE to ACCESS with byte counter k = 0.
REQ-026 SHALL, in ACCESS, hold mem_addr = base + k (modulo 2^32, wrapping) for exactly one cycle per byte, with exactly one of mem_read/mem_write high.
REQ-027 SHALL drive mem_wdata[7:0] = wdata[8k+7:8k] on store cycles.
REQ-028 SHALL, on load cycles, capture mem_rdata[7:0] into assembly byte k at the cycle's rising edge.
REQ-029 SHALL increment k each ACCESS cycle and go to RESP after byte N-1, so ACCESS lasts N cycles.
REQ-030 SHALL, in RESP, assert resp_valid for 1 cycle and then return to IDLE; total latency from accept edge to resp_valid is N+1 cycles (1 cycle on error).
REQ-031 SHALL form resp_rdata as: b/h sign-extended from bit 7/15, bu/hu zero-extended, w unchanged.
REQ-032 SHALL drive mem_read, mem_write, mem_addr, and mem_wdata to 0 outside ACCESS, and resp_rdata/resp_err to 0 when resp_valid = 0.

Reset
REQ-033 SHALL, while reset = 0, force IDLE, k = 0, assembly = 0, req_ready = 1, and all other outputs = 0, immediately and independent of clk.
REQ-034 SHALL, on reset asserted mid-ACCESS, abort the access with no response; store bytes already written remain in memory (partial store is permitted).

Verification
REQ-035 SHALL cover: sw addr 0x10, wdata 0xDEADBEEF -> mem_write for 4 cycles at 0x10..0x13 with bytes EF, BE, AD, DE; resp_valid in cycle 5, err = 0, rdata = 0.
REQ-036 SHALL cover: lw 0x10 after REQ-035 -> 4 mem_read cycles; resp_rdata = 0xDEADBEEF.
REQ-037 SHALL cover: lh 0x12 -> 0xFFFFDEAD; lhu 0x12 -> 0x0000DEAD; lb 0x13 -> 0xFFFFFFDE; lbu 0x10 -> 0x000000EF.
REQ-038 SHALL cover: lw 0x11 and sh 0x13 (ALIGN_CHECK = 1) -> no memory strobes; resp_valid 1 cycle after accept, err = 1, rdata = 0.
REQ-039 SHALL cover: funct3 011 load and sbu (100, write = 1) -> err = 1 after 1 cycle; req_valid held during a busy sw is ignored, with no second response.
REQ-040 SHALL cover: reset driven low after the 2nd byte of sw 0x20 = 0x11223344 -> outputs 0 asynchronously; after release, req_ready = 1, memory holds 44, 33 at 0x20/0x21, and no resp_valid is produced.
